// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Holds the arbiter state encoding, the port indices and the reset value of the last-grant pointer.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_OWN0 = 2'd1,
        ARB_OWN1 = 2'd2
    } arb_state_e;

    localparam int CPU_PORT = 0;
    localparam int DBG_PORT = 1;

    // A last-grant value of 1 makes port 0 win the first tie after reset.
    localparam logic LAST_RST = 1'b1;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Combinational two-way pick with a one-hot grant output.
// On a tie, the port that was not granted last wins, or port 0 always wins when fixed_prio_i is set.
module rr_pick2 (
    input  logic [1:0] req_i,
    input  logic       last_i,
    input  logic       fixed_prio_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = 2'b00;
        if (req_i == 2'b01) begin
            gnt_o = 2'b01;
        end else if (req_i == 2'b10) begin
            gnt_o = 2'b10;
        end else if (req_i == 2'b11) begin
            gnt_o = (fixed_prio_i || last_i) ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter that lets the CPU (port 0) and the debug/loader master (port 1) share one single-port memory, with per-port lock.
// Define MEM_ARB_FIXED_PRIO_EN to make port 0 win every tie in IDLE; round-robin is used otherwise.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            req,
    input  logic [1:0]            lock,
    input  logic [1:0]            we,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic [1:0]            gnt,
    output logic [1:0]            rvalid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    input  logic [DATA_WIDTH-1:0] mem_out,
    output logic [1:0]            dbg_state_o
);

`ifdef MEM_ARB_FIXED_PRIO_EN
    localparam logic FIXED_PRIO = 1'b1;
`else
    localparam logic FIXED_PRIO = 1'b0;
`endif

    arb_state_e state_q, state_d;
    logic       last_q, last_d;
    logic [1:0] rvalid_q, rvalid_d;
    logic [1:0] pick_gnt;
    logic [1:0] gnt_c;

    rr_pick2 u_pick (
        .req_i        (req),
        .last_i       (last_q),
        .fixed_prio_i (FIXED_PRIO),
        .gnt_o        (pick_gnt)
    );

    // Handshake: port i presents req[i] with stable we/addr/wdata; an access is
    // performed in every cycle where gnt[i]=1, and a read returns rvalid[i] one cycle later.
    always_comb begin
        state_d = state_q;
        gnt_c   = 2'b00;
        unique case (state_q)
            ARB_IDLE: begin
                gnt_c = pick_gnt;
                if (gnt_c[CPU_PORT] && lock[CPU_PORT]) begin
                    state_d = ARB_OWN0;
                end else if (gnt_c[DBG_PORT] && lock[DBG_PORT]) begin
                    state_d = ARB_OWN1;
                end
            end
            ARB_OWN0: begin
                gnt_c = {1'b0, req[CPU_PORT]};
                if (!lock[CPU_PORT] || !req[CPU_PORT]) begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_OWN1: begin
                gnt_c = {req[DBG_PORT], 1'b0};
                if (!lock[DBG_PORT] || !req[DBG_PORT]) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase

        // Nothing reaches the memory while reset is held.
        if (!rst_n) begin
            gnt_c = 2'b00;
        end

        last_d = last_q;
        if (gnt_c[CPU_PORT]) begin
            last_d = 1'b0;
        end else if (gnt_c[DBG_PORT]) begin
            last_d = 1'b1;
        end

        rvalid_d = gnt_c & ~we;

        mem_we   = 1'b0;
        mem_addr = '0;
        mem_data = '0;
        if (gnt_c[CPU_PORT]) begin
            mem_we   = we[CPU_PORT];
            mem_addr = addr0;
            mem_data = wdata0;
        end else if (gnt_c[DBG_PORT]) begin
            mem_we   = we[DBG_PORT];
            mem_addr = addr1;
            mem_data = wdata1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ARB_IDLE;
            last_q   <= LAST_RST;
            rvalid_q <= 2'b00;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign gnt         = gnt_c;
    // Gating with rst_n drops a read that is still in flight as soon as reset is asserted.
    assign rvalid      = rvalid_q & {2{rst_n}};
    assign rdata       = mem_out;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: a table of per-cycle vectors, hand-written reset sequences, and a scoreboard for read data.
// Compile with MEM_ARB_FIXED_PRIO_EN to use the fixed-priority vector table.
module tb_mem_arbiter;

  localparam int AW = 6;
  localparam int DW = 16;

  logic          clk;
  logic          rst_n;
  logic [1:0]    req, lock, we;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic [1:0]    gnt, rvalid, dbg_state;
  logic [DW-1:0] rdata;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic [DW-1:0] mem_out;

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .lock        (lock),
    .we          (we),
    .addr0       (addr0),
    .addr1       (addr1),
    .wdata0      (wdata0),
    .wdata1      (wdata1),
    .gnt         (gnt),
    .rvalid      (rvalid),
    .rdata       (rdata),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .mem_out     (mem_out),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory behind the arbiter: registered read, one cycle of latency
  logic [DW-1:0] mem [64];
  logic [DW-1:0] ref_mem [64];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_data;
    mem_out <= mem[mem_addr];
  end

  typedef struct {
    logic [1:0]    req;
    logic [1:0]    lock;
    logic [1:0]    we;
    logic [AW-1:0] a0;
    logic [AW-1:0] a1;
    logic [DW-1:0] d0;
    logic [DW-1:0] d1;
    logic [1:0]    gnt;
  } vec_t;

  vec_t vecs[$];
  logic [DW:0] exp_q[$];
  logic [1:0]  pend_rv;
  int          tests;
  int          failed;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic [1:0] r, input logic [1:0] l, input logic [1:0] w,
                     input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                     input logic [DW-1:0] d0, input logic [DW-1:0] d1, input logic [1:0] g);
    vecs.push_back('{r, l, w, a0, a1, d0, d1, g});
  endtask

  // driver: one vector per cycle, checked at the falling edge
  task automatic run_vec(input vec_t v);
    logic [DW:0]   e;
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;
    req = v.req; lock = v.lock; we = v.we;
    addr0 = v.a0; addr1 = v.a1; wdata0 = v.d0; wdata1 = v.d1;
    @(negedge clk);
    chk("gnt", {30'd0, gnt}, {30'd0, v.gnt});
    e_we = 1'b0; e_addr = '0; e_data = '0;
    if (v.gnt[0]) begin
      e_we = v.we[0]; e_addr = v.a0; e_data = v.d0;
    end else if (v.gnt[1]) begin
      e_we = v.we[1]; e_addr = v.a1; e_data = v.d1;
    end
    chk("mem_we", {31'd0, mem_we}, {31'd0, e_we});
    chk("mem_addr", {26'd0, mem_addr}, {26'd0, e_addr});
    chk("mem_data", {16'd0, mem_data}, {16'd0, e_data});
    chk("rvalid", {30'd0, rvalid}, {30'd0, pend_rv});
    if (rvalid != 2'b00) begin
      if (exp_q.size() == 0) begin
        chk("rdata_unexpected", {30'd0, rvalid}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("rdata", {15'd0, rvalid[1], rdata}, {15'd0, e});
      end
    end
    pend_rv = v.gnt & ~v.we;
    if (pend_rv[0]) exp_q.push_back({1'b0, ref_mem[v.a0]});
    else if (pend_rv[1]) exp_q.push_back({1'b1, ref_mem[v.a1]});
    if (v.gnt[0] && v.we[0]) ref_mem[v.a0] = v.d0;
    else if (v.gnt[1] && v.we[1]) ref_mem[v.a1] = v.d1;
    @(posedge clk); #1;
  endtask

  task automatic fill_table();
`ifdef MEM_ARB_FIXED_PRIO_EN
    for (int i = 0; i < 4; i++)
      add(2'b11, 2'b00, 2'b00, AW'($urandom_range(0, 63)), AW'($urandom_range(0, 63)), 16'h0, 16'h0, 2'b01);
    add(2'b10, 2'b00, 2'b00, 6'd0, 6'd9, 16'h0, 16'h0, 2'b10);
    add(2'b00, 2'b00, 2'b00, 6'd0, 6'd0, 16'h0, 16'h0, 2'b00);
    add(2'b10, 2'b10, 2'b00, 6'd0, 6'd4, 16'h0, 16'h0, 2'b10);
    add(2'b11, 2'b10, 2'b00, 6'd1, 6'd4, 16'h0, 16'h0, 2'b10);
    add(2'b11, 2'b00, 2'b00, 6'd1, 6'd4, 16'h0, 16'h0, 2'b10);
    add(2'b11, 2'b00, 2'b00, 6'd1, 6'd4, 16'h0, 16'h0, 2'b01);
    add(2'b00, 2'b00, 2'b00, 6'd0, 6'd0, 16'h0, 16'h0, 2'b00);
`else
    // first tie after reset, then the write/read handoff through address 5
    add(2'b11, 2'b00, 2'b00, 6'd1, 6'd2, 16'h0, 16'h0, 2'b01);
    add(2'b01, 2'b00, 2'b01, 6'd5, 6'd0, 16'hBEEF, 16'h0, 2'b01);
    add(2'b10, 2'b00, 2'b00, 6'd0, 6'd5, 16'h0, 16'h0, 2'b10);
    add(2'b00, 2'b00, 2'b00, 6'd0, 6'd0, 16'h0, 16'h0, 2'b00);
    // back-to-back reads from both ports alternate
    for (int i = 0; i < 6; i++)
      add(2'b11, 2'b00, 2'b00, AW'($urandom_range(0, 63)), AW'($urandom_range(0, 63)),
          16'h0, 16'h0, (i % 2 == 0) ? 2'b01 : 2'b10);
    // port 1 locks for four grants while port 0 waits
    add(2'b01, 2'b00, 2'b00, 6'd7, 6'd0, 16'h0, 16'h0, 2'b01);
    for (int i = 0; i < 4; i++)
      add(2'b11, 2'b10, 2'b00, 6'd8, AW'(10 + i), 16'h0, 16'h0, 2'b10);
    add(2'b01, 2'b00, 2'b00, 6'd8, 6'd0, 16'h0, 16'h0, 2'b00);
    add(2'b01, 2'b00, 2'b00, 6'd8, 6'd0, 16'h0, 16'h0, 2'b01);
    // lock with no request is ignored
    add(2'b00, 2'b01, 2'b00, 6'd0, 6'd0, 16'h0, 16'h0, 2'b00);
    add(2'b10, 2'b00, 2'b00, 6'd0, 6'd3, 16'h0, 16'h0, 2'b10);
    // port 0 ownership, released by dropping lock; port 1 goes next
    add(2'b11, 2'b01, 2'b01, 6'd20, 6'd30, 16'h1234, 16'h0, 2'b01);
    add(2'b11, 2'b01, 2'b00, 6'd20, 6'd30, 16'h0, 16'h0, 2'b01);
    add(2'b11, 2'b00, 2'b00, 6'd21, 6'd30, 16'h0, 16'h0, 2'b01);
    add(2'b11, 2'b00, 2'b10, 6'd21, 6'd20, 16'h0, 16'h5A5A, 2'b10);
    add(2'b10, 2'b00, 2'b00, 6'd0, 6'd20, 16'h0, 16'h0, 2'b10);
    add(2'b00, 2'b00, 2'b00, 6'd0, 6'd0, 16'h0, 16'h0, 2'b00);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tests = 0; failed = 0; pend_rv = 2'b00;
    for (int i = 0; i < 64; i++) begin
      mem[i] = 16'h1000 + 16'(i * 7);
      ref_mem[i] = 16'h1000 + 16'(i * 7);
    end
    rst_n = 1'b0; req = 2'b11; lock = 2'b00; we = 2'b00;
    addr0 = 6'd1; addr1 = 6'd2; wdata0 = '0; wdata1 = '0;
    fill_table();

    // hold reset while both ports request
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_gnt", {30'd0, gnt}, 32'd0);
      chk("rst_rvalid", {30'd0, rvalid}, 32'd0);
      chk("rst_mem_addr", {26'd0, mem_addr}, 32'd0);
      chk("rst_state", {30'd0, dbg_state}, 32'd0);
      @(posedge clk); #1;
    end
    rst_n = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // reset lands the cycle after a locked read grant
    req = 2'b01; lock = 2'b01; we = 2'b00; addr0 = 6'd3;
    @(negedge clk);
    chk("pre_rst_gnt", {30'd0, gnt}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0; req = 2'b00; lock = 2'b00;
    @(negedge clk);
    chk("mid_rst_rvalid", {30'd0, rvalid}, 32'd0);
    chk("mid_rst_gnt", {30'd0, gnt}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("post_rst_rvalid", {30'd0, rvalid}, 32'd0);
    chk("post_rst_state", {30'd0, dbg_state}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    pend_rv = 2'b00;
    run_vec('{2'b11, 2'b00, 2'b00, 6'd4, 6'd6, 16'h0, 16'h0, 2'b01});
    run_vec('{2'b00, 2'b00, 2'b00, 6'd0, 6'd0, 16'h0, 16'h0, 2'b00});

    chk("sb_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
